ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Consumer end of the program-counter interface: accepts word addresses from the PC stage and issues in-order read requests to instruction memory.
- Buffers the returned instructions, each tagged with its address, in a small FIFO for decode.
- On redirect (branch/jump/clear) it discards queued and in-flight fetches, so the PC's next address is the first instruction delivered.

Parameters:
- DEPTH, 4, entries in the instruction FIFO and max outstanding requests; power of 2, ≥2.
- ADDR_W, 32, word-address width. Low byte-offset bits are never carried.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- pc_valid  in  1  pc_addr holds a fetch address.
- pc_addr  in  ADDR_W  word address to fetch.
- pc_ready  out  1  address accepted this cycle when pc_valid && pc_ready.
- flush  in  1  redirect; discard all buffered and in-flight fetches.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  ADDR_W  request word address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  memory returns data, in request order, ≥1 cycle after acceptance.
- mem_resp_data  in  DATA_W  instruction word.
- out_valid  out  1  out_instr/out_pc valid.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  address of head instruction.
- out_ready  in  1  decode consumes head when out_valid && out_ready.

Behaviour:
- Reset (clr=1): FIFO empty, outstanding=0, drop=0, state RUN. Outputs: out_valid=0, mem_req_valid=0, pc_ready=0, out_instr=0, out_pc=0. clr overrides flush and all handshakes.
- Request path is combinational pass-through, gated by credit:
  - mem_req_valid = pc_valid && credit && !flush
  - mem_req_addr = pc_addr
  - pc_ready = mem_req_ready && credit && !flush
  - credit = (fifo_count + outstanding) < DEPTH
- On request accept: push pc_addr into the tag queue (DEPTH entries); outstanding += 1.
- On response with drop==0: pop the tag and push {tag, data} into the instruction FIFO; outstanding -= 1.
- On response with drop>0: discard data and tag; drop -= 1.
- Accept and response in the same cycle: outstanding is unchanged.
- The credit rule guarantees the FIFO never overflows. A response arriving with the FIFO full is a protocol violation (assertion).
- Output is registered from the FIFO head: out_valid = fifo not empty. Minimum latency from response to out_valid is 1 cycle.
- Pop on out_valid && out_ready. Push and pop in the same cycle are allowed when full or empty.
- Flush, effective at the edge:
  - Instruction FIFO cleared.
  - drop = drop + outstanding, minus 1 if a response arrives that cycle with drop==0.
  - outstanding=0 and tag queue cleared.
  - No request issued in the flush cycle.
- States: RUN (drop==0) and DRAIN (drop>0).
  - RUN→DRAIN on flush with in-flight requests.
  - DRAIN→RUN when the last dropped response arrives.
  - New requests are permitted in DRAIN; their credit counts drop + outstanding.
  - Responses are matched FIFO-order, so dropped responses always precede new ones.
- Counters are width clog2(DEPTH)+1 and saturate-free by construction.
- A second flush during DRAIN accumulates into drop.
- Pointer wrap-around: modulo DEPTH.

Optional Feature:
- Macro IFETCH_STATS_EN.
- When defined, adds outputs stat_fetched[31:0] and stat_dropped[31:0]:
  - stat_fetched counts FIFO pushes.
  - stat_dropped counts discarded responses plus FIFO entries cleared by flush.
  - Both wrap at 2^32 and clear on clr.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- defines.vh gains IFETCH_DEPTH_DEFAULT and state encodings IFETCH_RUN=1'b0, IFETCH_DRAIN=1'b1.
- One sub-module, ifetch_fifo: parameterised synchronous FIFO (push, pop, clear, full, empty, count). It is instantiated twice, for the tag queue and for the instruction FIFO.

Test Plan:
- Streaming: pc 0..7 sequential, memory 1-cycle latency, out_ready=1 → out_pc 0..7 in order, out_instr equals memory contents, no bubbles after first.
- Backpressure: out_ready=0, pc stream 0.. → exactly 4 requests accepted, then pc_ready=0. Release out_ready → remaining fetched in order.
- Flush in flight: issue addrs 0x10..0x12 with 3-cycle latency, flush, then pc=0x40 → three responses dropped, first out_pc=0x40, no 0x10–0x12 delivered.
- Flush with simultaneous response and out pop: FIFO holds 2, 1 outstanding, response and flush in same cycle → out_valid=0 next cycle, drop=0 (response consumed as drop).
- clr mid-DRAIN: drop=2, assert clr → all outputs reset values next cycle, state RUN.
- IFETCH_STATS_EN: 5 fetches, flush with 2 in flight and 1 buffered → stat_fetched=3 (2 delivered before flush + 1 buffered), stat_dropped=3.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default sizes,
// RUN/DRAIN state encodings and a counter-width helper.
package ifetch_unit_pkg;

  localparam int unsigned IFETCH_DEPTH_DEFAULT  = 4;
  localparam int unsigned IFETCH_ADDR_W_DEFAULT = 32;
  localparam int unsigned IFETCH_DATA_W_DEFAULT = 32;

  localparam logic IFETCH_RUN   = 1'b0;
  localparam logic IFETCH_DRAIN = 1'b1;

  typedef enum logic {
    ST_RUN   = IFETCH_RUN,
    ST_DRAIN = IFETCH_DRAIN
  } ifetch_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned ifetch_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with clear; used for both the tag queue and the
// instruction buffer. DEPTH must be a power of two so pointers wrap freely.
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = ifetch_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (clr || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: forwards PC addresses to instruction memory under
// a credit limit, tags responses with their address and buffers them for
// decode. A flush discards buffered entries and marks in-flight responses to
// be dropped. Optional counters are enabled with IFETCH_STATS_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = IFETCH_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = IFETCH_ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = IFETCH_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int unsigned CNT_W   = ifetch_cnt_w(DEPTH);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  ifetch_state_e      state;
  logic [CNT_W-1:0]   drop;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   flush_drop;
  logic               tag_full;
  logic               tag_empty;
  logic               fifo_full;
  logic               fifo_empty;
  logic               credit;
  logic               req_fire;
  logic               resp_keep;
  logic               out_fire;
  logic [ADDR_W-1:0]  tag_head;
  logic [ENTRY_W-1:0] fifo_head;

  // Credit covers buffered, outstanding and to-be-dropped fetches.
  assign credit = (SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(drop))
                  < SUM_W'(DEPTH);

  assign mem_req_valid = pc_valid && credit && !flush && !clr;
  assign mem_req_addr  = pc_addr;
  assign pc_ready      = mem_req_ready && credit && !flush && !clr;
  assign req_fire      = pc_valid && pc_ready;

  // Only responses arriving in RUN, outside a flush, are kept.
  assign resp_keep = mem_resp_valid && (state == ST_RUN) && !flush && !clr;

  assign out_valid = !fifo_empty;
  assign out_fire  = out_valid && out_ready;
  assign out_instr = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_pc    = fifo_empty ? '0 : fifo_head[ENTRY_W-1:DATA_W];

  // A response in the flush cycle retires one in-flight fetch as a drop.
  assign flush_drop = CNT_W'(SUM_W'(drop) + SUM_W'(outstanding)
                             - SUM_W'(mem_resp_valid));

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_tag_q (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .push  (req_fire),
    .pop   (resp_keep),
    .din   (pc_addr),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_instr_q (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .push  (resp_keep),
    .pop   (out_fire),
    .din   ({tag_head, mem_resp_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // RUN/DRAIN state with the count of responses still to be discarded.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_RUN;
      drop  <= '0;
    end else if (flush) begin
      drop  <= flush_drop;
      state <= (flush_drop != '0) ? ST_DRAIN : ST_RUN;
    end else if (mem_resp_valid && (state == ST_DRAIN)) begin
      drop  <= drop - CNT_W'(1);
      state <= (drop == CNT_W'(1)) ? ST_RUN : ST_DRAIN;
    end
  end

`ifdef IFETCH_STATS_EN
  logic             resp_discard;
  logic [CNT_W-1:0] flushed_entries;

  assign resp_discard    = mem_resp_valid && (flush || (state == ST_DRAIN));
  assign flushed_entries = flush ? (fifo_count - CNT_W'(out_fire)) : '0;

  // Fetch/discard event counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(resp_keep);
      stat_dropped <= stat_dropped + 32'(resp_discard) + 32'(flushed_entries);
    end
  end
`endif

  // Memory-side protocol checks: responses must match a request and never
  // land on a full buffer; requests must never exceed tag storage.
  a_resp_has_tag : assert property (@(posedge clk) disable iff (clr)
    (mem_resp_valid && (state == ST_RUN)) |-> !tag_empty);
  a_no_overflow : assert property (@(posedge clk) disable iff (clr)
    resp_keep |-> (!fifo_full || out_fire));
  a_tag_bound : assert property (@(posedge clk) disable iff (clr)
    req_fire |-> !tag_full);

endmodule
